// File: rtl/key_debounce_if.sv
// -----------------------------------------------------------------------------
// key_debounce_if
//   Bundles the key pins and the debounced level/event outputs of
//   key_debounce into one interface.
//
//   Parameters
//     NUM_KEYS  number of key channels carried by the bundle
//
//   Signals (all NUM_KEYS wide)
//     key_in    raw asynchronous key pins, 0 = pressed
//     key_db    debounced level, same polarity as key_in
//     key_fall  1-cycle pulse on committed press (1->0)
//     key_rise  1-cycle pulse on committed release (0->1)
//     key_long  1-cycle pulse on long press (0 when the feature is not built)
//
//   Modports
//     master  board/stimulus side: drives key_in, receives the outputs
//     slave   debouncer side: receives key_in, drives the outputs
// -----------------------------------------------------------------------------
interface key_debounce_if #(
  parameter int NUM_KEYS = 4
);
  logic [NUM_KEYS-1:0] key_in;
  logic [NUM_KEYS-1:0] key_db;
  logic [NUM_KEYS-1:0] key_fall;
  logic [NUM_KEYS-1:0] key_rise;
  logic [NUM_KEYS-1:0] key_long;

  modport master (
    output key_in,
    input  key_db,
    input  key_fall,
    input  key_rise,
    input  key_long
  );

  modport slave (
    input  key_in,
    output key_db,
    output key_fall,
    output key_rise,
    output key_long
  );
endinterface

// File: rtl/key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
//   Per-key debouncer and edge-event generator for active-low push-buttons
//   (idle high). Each key is synchronised by two flops, then a four-state FSM
//   (S_HI, W_LO, S_LO, W_HI) only commits a new level once it has been seen
//   continuously for DEBOUNCE_CYCLES cycles. Commits produce registered
//   one-cycle key_fall / key_rise pulses; key_db is the clean level.
//
//   Optional feature (macro KEY_LONG_PRESS_EN):
//     defined   -> per-key long-press counter; key_long pulses once when a
//                  committed press has lasted LONG_CYCLES cycles.
//     undefined -> no long-press logic, key_long is tied to 0.
//   The port list is the same in both builds.
//
//   Parameters
//     NUM_KEYS         number of independent key channels
//     DEBOUNCE_CYCLES  cycles a new level must hold before commit (>= 1)
//     LONG_CYCLES      cycles held low after commit before key_long (>= 1)
//
//   Ports
//     clk      system clock
//     reset_n  synchronous, active-low reset
//     bus      key_debounce_if.slave: key_in in, key_db/key_fall/key_rise/
//              key_long out
// -----------------------------------------------------------------------------
module key_debounce #(
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int LONG_CYCLES     = 50_000_000
) (
  input  logic            clk,
  input  logic            reset_n,
  key_debounce_if.slave   bus
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_HI = 2'd0,  // stable high (released)
    W_LO = 2'd1,  // low seen, qualifying
    S_LO = 2'd2,  // stable low (pressed)
    W_HI = 2'd3   // high seen, qualifying
  } state_e;

  // Elaboration-time guard: both counters need at least one cycle.
  if (DEBOUNCE_CYCLES < 1 || LONG_CYCLES < 1) begin : g_bad_param
    $error("key_debounce: DEBOUNCE_CYCLES and LONG_CYCLES must be >= 1");
  end

  // ---------------------------------------------------------------------------
  // Two-flop synchronisers, reset to the idle (released) level.
  // ---------------------------------------------------------------------------
  logic [NUM_KEYS-1:0] sync1_q;
  logic [NUM_KEYS-1:0] sync2_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= bus.key_in;
      sync2_q <= sync1_q;
    end
  end

  logic [NUM_KEYS-1:0] db_vec;
  logic [NUM_KEYS-1:0] fall_vec;
  logic [NUM_KEYS-1:0] rise_vec;
  logic [NUM_KEYS-1:0] long_vec;

  // ---------------------------------------------------------------------------
  // Per-key debounce FSM
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          db_q, db_d;
    logic          fall_q, fall_d;
    logic          rise_q, rise_d;
    logic          samp;
    logic          commit_lo;
    logic          commit_hi;

    assign samp = sync2_q[gi];

    // State register
    always_ff @(posedge clk) begin
      if (!reset_n) begin
        state_q <= S_HI;
        cnt_q   <= '0;
        db_q    <= 1'b1;
        fall_q  <= 1'b0;
        rise_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        db_q    <= db_d;
        fall_q  <= fall_d;
        rise_q  <= rise_d;
      end
    end

    // Next-state logic. cnt counts consecutive qualifying samples; any
    // opposite sample drops back to the stable state and restarts from 0.
    always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      commit_lo = 1'b0;
      commit_hi = 1'b0;
      case (state_q)
        S_HI: begin
          if (!samp) begin
            state_d = W_LO;
            cnt_d   = '0;
          end
        end
        W_LO: begin
          if (samp) begin
            state_d = S_HI;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d   = S_LO;
            cnt_d     = '0;
            commit_lo = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_LO: begin
          if (samp) begin
            state_d = W_HI;
            cnt_d   = '0;
          end
        end
        W_HI: begin
          if (!samp) begin
            state_d = S_LO;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d   = S_HI;
            cnt_d     = '0;
            commit_hi = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = S_HI;
          cnt_d   = '0;
        end
      endcase
    end

    // Output logic: level and pulses follow the commit decisions, and are
    // registered so they all change on the commit edge.
    always_comb begin
      db_d   = db_q;
      fall_d = commit_lo;
      rise_d = commit_hi;
      if (commit_lo) db_d = 1'b0;
      if (commit_hi) db_d = 1'b1;
    end

    assign db_vec[gi]   = db_q;
    assign fall_vec[gi] = fall_q;
    assign rise_vec[gi] = rise_q;

`ifdef KEY_LONG_PRESS_EN
    localparam int            LW        = $clog2(LONG_CYCLES + 1);
    localparam logic [LW-1:0] LCNT_LAST = LW'(LONG_CYCLES - 1);
    localparam logic [LW-1:0] LCNT_MAX  = LW'(LONG_CYCLES);

    logic [LW-1:0] lcnt_q, lcnt_d;
    logic          long_q, long_d;

    always_ff @(posedge clk) begin
      if (!reset_n) begin
        lcnt_q <= '0;
        long_q <= 1'b0;
      end else begin
        lcnt_q <= lcnt_d;
        long_q <= long_d;
      end
    end

    // lcnt runs while the key is logically pressed (S_LO, and W_HI so that a
    // release bounce does not restart it). It parks at LONG_CYCLES, which
    // never matches LCNT_LAST again, so one pulse per press. A release that
    // commits on the same edge wins over the long pulse.
    always_comb begin
      lcnt_d = lcnt_q;
      long_d = 1'b0;
      if (commit_lo) begin
        lcnt_d = '0;
      end else if ((state_q == S_LO || state_q == W_HI) && !commit_hi) begin
        if (lcnt_q != LCNT_MAX) lcnt_d = lcnt_q + LW'(1);
        if (lcnt_q == LCNT_LAST) long_d = 1'b1;
      end
    end

    assign long_vec[gi] = long_q;
`else
    assign long_vec[gi] = 1'b0;
`endif
  end

  assign bus.key_db   = db_vec;
  assign bus.key_fall = fall_vec;
  assign bus.key_rise = rise_vec;
  assign bus.key_long = long_vec;

endmodule

// File: tb/tb_key_debounce.sv
// -----------------------------------------------------------------------------
// tb_key_debounce
//   Directed bench for key_debounce with NUM_KEYS=2, DEBOUNCE_CYCLES=8,
//   LONG_CYCLES=40. Inputs change #1 after a rising edge, so the next rising
//   edge is E1; a commit is visible after edge E1+10, i.e. 11 steps later.
//   Expected long-press behaviour follows KEY_LONG_PRESS_EN.
// -----------------------------------------------------------------------------
module tb_key_debounce;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

`ifdef KEY_LONG_PRESS_EN
  localparam logic [1:0] LONG_PULSE = 2'b01;
  localparam int         LONG_EXP   = 1;
`else
  localparam logic [1:0] LONG_PULSE = 2'b00;
  localparam int         LONG_EXP   = 0;
`endif

  key_debounce_if #(.NUM_KEYS(2)) bus ();

  key_debounce #(
    .NUM_KEYS(2),
    .DEBOUNCE_CYCLES(8),
    .LONG_CYCLES(40)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Pulse counters, sampled mid-cycle.
  int fall_cnt[2] = '{0, 0};
  int rise_cnt[2] = '{0, 0};
  int long_cnt[2] = '{0, 0};

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (bus.key_fall[k] === 1'b1) fall_cnt[k] <= fall_cnt[k] + 1;
      if (bus.key_rise[k] === 1'b1) rise_cnt[k] <= rise_cnt[k] + 1;
      if (bus.key_long[k] === 1'b1) long_cnt[k] <= long_cnt[k] + 1;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    reset_n    = 1'b0;
    bus.key_in = 2'b11;
    step(3);
    checks++; if (bus.key_db !== 2'b11) begin errors++; $display("FAIL reset_db: got %b want 11", bus.key_db); end
    checks++; if (bus.key_fall !== 2'b00) begin errors++; $display("FAIL reset_fall: got %b want 00", bus.key_fall); end
    checks++; if (bus.key_rise !== 2'b00) begin errors++; $display("FAIL reset_rise: got %b want 00", bus.key_rise); end
    checks++; if (bus.key_long !== 2'b00) begin errors++; $display("FAIL reset_long: got %b want 00", bus.key_long); end
    reset_n = 1'b1;
    step(3);
    checks++; if (bus.key_db !== 2'b11) begin errors++; $display("FAIL idle_db: got %b want 11", bus.key_db); end
    $display("test_reset done");
  endtask

  task automatic test_clean_press;
    bus.key_in = 2'b10;
    step(10);  // after E1+9
    checks++; if (bus.key_db !== 2'b11 || bus.key_fall !== 2'b00) begin errors++; $display("FAIL press_early: db=%b fall=%b want 11/00", bus.key_db, bus.key_fall); end
    step(1);   // after E1+10
    checks++; if (bus.key_db !== 2'b10) begin errors++; $display("FAIL press_db: got %b want 10", bus.key_db); end
    checks++; if (bus.key_fall !== 2'b01) begin errors++; $display("FAIL press_fall: got %b want 01", bus.key_fall); end
    step(1);   // after E1+11
    checks++; if (bus.key_fall !== 2'b00 || bus.key_db !== 2'b10) begin errors++; $display("FAIL press_after: fall=%b db=%b want 00/10", bus.key_fall, bus.key_db); end
    $display("test_clean_press done");
  endtask

  task automatic test_release;
    int f0;
    f0 = fall_cnt[0];
    bus.key_in = 2'b11;
    step(10);
    checks++; if (bus.key_db !== 2'b10 || bus.key_rise !== 2'b00) begin errors++; $display("FAIL rel_early: db=%b rise=%b want 10/00", bus.key_db, bus.key_rise); end
    step(1);
    checks++; if (bus.key_rise !== 2'b01 || bus.key_db !== 2'b11) begin errors++; $display("FAIL rel_commit: rise=%b db=%b want 01/11", bus.key_rise, bus.key_db); end
    step(1);
    checks++; if (bus.key_rise !== 2'b00) begin errors++; $display("FAIL rel_after: rise=%b want 00", bus.key_rise); end
    checks++; if (fall_cnt[0] != f0) begin errors++; $display("FAIL rel_nofall: got %0d falls want 0", fall_cnt[0] - f0); end
    $display("test_release done");
  endtask

  task automatic test_bounce;
    int f0;
    f0 = fall_cnt[0];
    bus.key_in = 2'b10; step(5);
    bus.key_in = 2'b11; step(1);
    bus.key_in = 2'b10; step(3);
    bus.key_in = 2'b11; step(2);
    bus.key_in = 2'b10;          // final low, held
    step(10);
    checks++; if (bus.key_db !== 2'b11 || fall_cnt[0] != f0) begin errors++; $display("FAIL bounce_quiet: db=%b falls=%0d want 11/0", bus.key_db, fall_cnt[0] - f0); end
    step(1);
    checks++; if (bus.key_fall !== 2'b01 || bus.key_db !== 2'b10) begin errors++; $display("FAIL bounce_commit: fall=%b db=%b want 01/10", bus.key_fall, bus.key_db); end
    step(5);
    checks++; if (fall_cnt[0] != f0 + 1) begin errors++; $display("FAIL bounce_once: got %0d falls want 1", fall_cnt[0] - f0); end
    bus.key_in = 2'b11;
    step(12);
    checks++; if (bus.key_db !== 2'b11) begin errors++; $display("FAIL bounce_release: db=%b want 11", bus.key_db); end
    $display("test_bounce done");
  endtask

  task automatic test_glitch;
    int f0, f1, r0, r1;
    f0 = fall_cnt[0]; f1 = fall_cnt[1]; r0 = rise_cnt[0]; r1 = rise_cnt[1];
    bus.key_in = 2'b01; step(7);
    bus.key_in = 2'b11; step(15);
    checks++; if (bus.key_db !== 2'b11) begin errors++; $display("FAIL glitch_db: got %b want 11", bus.key_db); end
    checks++; if (fall_cnt[0] != f0 || fall_cnt[1] != f1 || rise_cnt[0] != r0 || rise_cnt[1] != r1) begin
      errors++; $display("FAIL glitch_pulses: fall %0d/%0d rise %0d/%0d want all 0", fall_cnt[0]-f0, fall_cnt[1]-f1, rise_cnt[0]-r0, rise_cnt[1]-r1);
    end
    $display("test_glitch done");
  endtask

  task automatic test_simultaneous;
    bus.key_in = 2'b00;
    step(11);
    checks++; if (bus.key_fall !== 2'b11 || bus.key_db !== 2'b00) begin errors++; $display("FAIL simul_fall: fall=%b db=%b want 11/00", bus.key_fall, bus.key_db); end
    step(1);
    checks++; if (bus.key_fall !== 2'b00) begin errors++; $display("FAIL simul_fall_end: got %b want 00", bus.key_fall); end
    bus.key_in = 2'b11;
    step(11);
    checks++; if (bus.key_rise !== 2'b11 || bus.key_db !== 2'b11) begin errors++; $display("FAIL simul_rise: rise=%b db=%b want 11/11", bus.key_rise, bus.key_db); end
    step(1);
    checks++; if (bus.key_rise !== 2'b00) begin errors++; $display("FAIL simul_rise_end: got %b want 00", bus.key_rise); end
    $display("test_simultaneous done");
  endtask

  task automatic test_reset_mid;
    int f0;
    bus.key_in = 2'b10;
    step(8);            // after E1+7: cnt = 5
    f0 = fall_cnt[0];
    reset_n = 1'b0;
    step(1);            // reset edge R
    checks++; if (bus.key_db !== 2'b11 || bus.key_fall !== 2'b00 || bus.key_rise !== 2'b00) begin
      errors++; $display("FAIL rstmid_state: db=%b fall=%b rise=%b want 11/00/00", bus.key_db, bus.key_fall, bus.key_rise);
    end
    reset_n = 1'b1;
    step(10);           // after R+10
    checks++; if (bus.key_db !== 2'b11 || fall_cnt[0] != f0) begin errors++; $display("FAIL rstmid_early: db=%b falls=%0d want 11/0", bus.key_db, fall_cnt[0] - f0); end
    step(1);            // after R+11
    checks++; if (bus.key_fall !== 2'b01 || bus.key_db !== 2'b10) begin errors++; $display("FAIL rstmid_commit: fall=%b db=%b want 01/10", bus.key_fall, bus.key_db); end
    bus.key_in = 2'b11;
    step(12);
    $display("test_reset_mid done");
  endtask

  task automatic test_long_press;
    int l0, r0;
    l0 = long_cnt[0];
    bus.key_in = 2'b10;
    step(11);           // after commit edge C
    checks++; if (bus.key_fall !== 2'b01) begin errors++; $display("FAIL long_commit: fall=%b want 01", bus.key_fall); end
    step(39);           // after C+39
    checks++; if (bus.key_long !== 2'b00) begin errors++; $display("FAIL long_early: got %b want 00", bus.key_long); end
    step(1);            // after C+40
    checks++; if (bus.key_long !== LONG_PULSE) begin errors++; $display("FAIL long_pulse: got %b want %b", bus.key_long, LONG_PULSE); end
    step(1);
    checks++; if (bus.key_long !== 2'b00) begin errors++; $display("FAIL long_end: got %b want 00", bus.key_long); end
    step(19);           // held 60 cycles past commit
    checks++; if (long_cnt[0] != l0 + LONG_EXP) begin errors++; $display("FAIL long_count: got %0d want %0d", long_cnt[0] - l0, LONG_EXP); end
    bus.key_in = 2'b11;
    step(12);

    // Release 30 cycles after the press: release commits before lcnt expires.
    l0 = long_cnt[0];
    r0 = rise_cnt[0];
    bus.key_in = 2'b10;
    step(30);
    bus.key_in = 2'b11;
    step(25);
    checks++; if (long_cnt[0] != l0) begin errors++; $display("FAIL short_nolong: got %0d long pulses want 0", long_cnt[0] - l0); end
    checks++; if (rise_cnt[0] != r0 + 1 || bus.key_db !== 2'b11) begin errors++; $display("FAIL short_release: rises=%0d db=%b want 1/11", rise_cnt[0] - r0, bus.key_db); end
    checks++; if (long_cnt[1] != 0) begin errors++; $display("FAIL long_key1: got %0d want 0", long_cnt[1]); end
    $display("test_long_press done");
  endtask

  initial begin
    bus.key_in = 2'b11;
    test_reset();
    test_clean_press();
    test_release();
    test_bounce();
    test_glitch();
    test_simultaneous();
    test_reset_mid();
    test_long_press();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
